// File: rtl/mem_req_seq_pkg.sv
// Shared constants for the EX-side data-SRAM request sequencer:
// mem_op bit positions, FSM state encoding, byte-lane select patterns
// and pipeline stall-vector layout.
package mem_req_seq_pkg;

  // mem_op vector layout {lb,lbu,lh,lhu,lw,sb,sh,sw}
  localparam int MEMOP_LB  = 7;
  localparam int MEMOP_LBU = 6;
  localparam int MEMOP_LH  = 5;
  localparam int MEMOP_LHU = 4;
  localparam int MEMOP_LW  = 3;
  localparam int MEMOP_SB  = 2;
  localparam int MEMOP_SH  = 1;
  localparam int MEMOP_SW  = 0;

  // Byte-lane select patterns
  localparam logic [3:0] SEL_BYTE0 = 4'b0001;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  // Pipeline stall vector: one bit per stage, STOP holds that stage
  localparam int         STALL_W   = 6;
  localparam int         STALL_EX  = 3;
  localparam int         STALL_MEM = 4;
  localparam logic       STOP      = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mem_lane_dec.sv
// Per-slot combinational decode of a memory op: byte-lane select,
// write enable, replicated store data, word address and alignment faults.
// Optional build macro: MEM_ALIGN_CHK_EN enables alignment fault detection;
// without it, misaligned addresses are silently aligned and never fault.
module mem_lane_dec
  import mem_req_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              valid,
  input  logic [7:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        sel,
  output logic [3:0]        wen,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] word_addr,
  output logic              adel,
  output logic              ades,
  output logic              req
);

  logic       is_byte, is_half, is_word, is_load, is_store, is_mem, mis;
  logic [1:0] lo;

  // Classify the op, resolve lane offset and alignment, build lane outputs
  always_comb begin
    is_byte  = mem_op[MEMOP_LB] | mem_op[MEMOP_LBU] | mem_op[MEMOP_SB];
    is_half  = mem_op[MEMOP_LH] | mem_op[MEMOP_LHU] | mem_op[MEMOP_SH];
    is_word  = mem_op[MEMOP_LW] | mem_op[MEMOP_SW];
    is_load  = |mem_op[7:3];
    is_store = |mem_op[2:0];
    is_mem   = |mem_op;
`ifdef MEM_ALIGN_CHK_EN
    lo  = addr[1:0];
    mis = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
    lo  = is_half ? {addr[1], 1'b0} : (is_word ? 2'b00 : addr[1:0]);
    mis = 1'b0;
`endif
    sel = 4'b0000;
    if (is_byte)      sel = SEL_BYTE0 << lo;
    else if (is_half) sel = lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
    else if (is_word) sel = SEL_WORD;

    wdata = st_data;
    if (mem_op[MEMOP_SB])      wdata = {4{st_data[7:0]}};
    else if (mem_op[MEMOP_SH]) wdata = {2{st_data[15:0]}};

    word_addr = {addr[ADDR_W-1:2], 2'b00};
    adel      = valid & is_load & mis;
    ades      = valid & is_store & mis;
    req       = valid & is_mem & ~mis;
    wen       = (req & is_store) ? sel : 4'b0000;
  end

endmodule

// File: rtl/mem_req_seq.sv
// EX-side data-SRAM request sequencer for the dual-issue pipeline.
// Serialises two memory ops over one SRAM port (slot 1 then slot 2 with a
// one-cycle stall request) and buffers slot 1's load data for MEM.
// Optional build macro: MEM_ALIGN_CHK_EN (alignment faults and suppression).
module mem_req_seq
  import mem_req_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               valid_i1,
  input  logic               valid_i2,
  input  logic [7:0]         mem_op_i1,
  input  logic [7:0]         mem_op_i2,
  input  logic [ADDR_W-1:0]  addr_i1,
  input  logic [ADDR_W-1:0]  addr_i2,
  input  logic [DATA_W-1:0]  st_data_i1,
  input  logic [DATA_W-1:0]  st_data_i2,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_wen,
  output logic [ADDR_W-1:0]  data_sram_addr,
  output logic [DATA_W-1:0]  data_sram_wdata,
  output logic [3:0]         sel_i1,
  output logic [3:0]         sel_i2,
  output logic               adel_i1,
  output logic               adel_i2,
  output logic               ades_i1,
  output logic               ades_i2,
  output logic               stallreq_mem,
  output logic [DATA_W-1:0]  rdata_i1,
  output logic [DATA_W-1:0]  rdata_i2
);

  seq_state_t        state, state_nxt;
  logic [3:0]        wen1, wen2;
  logic [DATA_W-1:0] wdata1, wdata2, rbuf;
  logic [ADDR_W-1:0] waddr1, waddr2;
  logic              req1, req2_raw, req2, kill;
  logic              issue1, issue2, rbuf_v, cap_done, capture;

  mem_lane_dec #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dec1 (
    .valid(valid_i1), .mem_op(mem_op_i1), .addr(addr_i1), .st_data(st_data_i1),
    .sel(sel_i1), .wen(wen1), .wdata(wdata1), .word_addr(waddr1),
    .adel(adel_i1), .ades(ades_i1), .req(req1)
  );

  mem_lane_dec #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dec2 (
    .valid(valid_i2), .mem_op(mem_op_i2), .addr(addr_i2), .st_data(st_data_i2),
    .sel(sel_i2), .wen(wen2), .wdata(wdata2), .word_addr(waddr2),
    .adel(adel_i2), .ades(ades_i2), .req(req2_raw)
  );

  // A faulting slot 1 squashes the younger slot 2
  assign req2    = req2_raw & ~(adel_i1 | ades_i1);
  assign kill    = rst | flush;
  assign capture = (state == ST_SECOND) & ~cap_done & ~kill;

  // Next state, issue slot choice and stall request; flush/reset gate all
  always_comb begin
    state_nxt    = state;
    issue1       = 1'b0;
    issue2       = 1'b0;
    stallreq_mem = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req1 && req2) begin
          issue1       = 1'b1;
          stallreq_mem = 1'b1;
          state_nxt    = ST_SECOND;
        end else if (req1) begin
          issue1 = 1'b1;
        end else if (req2) begin
          issue2 = 1'b1;
        end
      end
      ST_SECOND: begin
        issue2    = req2;
        state_nxt = (stall[STALL_EX] == STOP) ? ST_SECOND : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) begin
      issue1       = 1'b0;
      issue2       = 1'b0;
      stallreq_mem = 1'b0;
      state_nxt    = ST_IDLE;
    end
  end

  // SRAM request mux: one slot owns the port per cycle
  always_comb begin
    data_sram_en    = issue1 | issue2;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (issue1) begin
      data_sram_wen   = wen1;
      data_sram_addr  = waddr1;
      data_sram_wdata = wdata1;
    end else if (issue2) begin
      data_sram_wen   = wen2;
      data_sram_addr  = waddr2;
      data_sram_wdata = wdata2;
    end
  end

  // State register, slot-1 read buffer and its valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rbuf     <= '0;
      rbuf_v   <= 1'b0;
      cap_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_done <= (state == ST_SECOND) & (state_nxt == ST_SECOND);
      if (capture) rbuf <= data_sram_rdata;
      if (flush) begin
        rbuf_v <= 1'b0;
      end else if (capture) begin
        rbuf_v <= 1'b1;
      end else if (state != ST_SECOND && stall[STALL_MEM] != STOP) begin
        rbuf_v <= 1'b0;
      end
    end
  end

  // MEM-stage read data per slot
  assign rdata_i2 = data_sram_rdata;
  assign rdata_i1 = rbuf_v ? rbuf : data_sram_rdata;

endmodule

// File: tb/tb_mem_req_seq.sv
// Directed self-checking bench for mem_req_seq with an expected-value queue.
module tb_mem_req_seq;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic        valid_i1, valid_i2;
  logic [7:0]  mem_op_i1, mem_op_i2;
  logic [31:0] addr_i1, addr_i2, st_data_i1, st_data_i2, data_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen, sel_i1, sel_i2;
  logic [31:0] data_sram_addr, data_sram_wdata, rdata_i1, rdata_i2;
  logic        adel_i1, adel_i2, ades_i1, ades_i2, stallreq_mem;

  localparam logic [7:0] OP_LB = 8'b1000_0000;
  localparam logic [7:0] OP_LW = 8'b0000_1000;
  localparam logic [7:0] OP_SH = 8'b0000_0010;
  localparam logic [7:0] OP_SW = 8'b0000_0001;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] sb_q[$];

  mem_req_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .valid_i1(valid_i1), .valid_i2(valid_i2),
    .mem_op_i1(mem_op_i1), .mem_op_i2(mem_op_i2),
    .addr_i1(addr_i1), .addr_i2(addr_i2),
    .st_data_i1(st_data_i1), .st_data_i2(st_data_i2),
    .data_sram_rdata(data_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .sel_i1(sel_i1), .sel_i2(sel_i2),
    .adel_i1(adel_i1), .adel_i2(adel_i2), .ades_i1(ades_i1), .ades_i2(ades_i2),
    .stallreq_mem(stallreq_mem), .rdata_i1(rdata_i1), .rdata_i2(rdata_i2)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_i1 = 0; valid_i2 = 0; mem_op_i1 = 0; mem_op_i2 = 0;
    addr_i1 = 0; addr_i2 = 0; st_data_i1 = 0; st_data_i2 = 0;
  endtask

  task automatic set_slot1(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    valid_i1 = 1; mem_op_i1 = op; addr_i1 = a; st_data_i1 = d;
  endtask

  task automatic set_slot2(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    valid_i2 = 1; mem_op_i2 = op; addr_i2 = a; st_data_i2 = d;
  endtask

  initial begin
    rst = 1; flush = 0; stall = 6'b0; data_sram_rdata = 32'h1234_5678;
    idle_inputs();
    set_slot1(OP_LW, 32'h100, 32'h0);
    tick();
    // Reset: request outputs gated, read path is a pass-through
    push(32'h0); push(32'h0); push(32'h0); push(32'h1234_5678);
    sample();
    check("rst_en", {31'b0, data_sram_en});
    check("rst_stallreq", {31'b0, stallreq_mem});
    check("rst_wen", {28'b0, data_sram_wen});
    check("rst_rdata_i1", rdata_i1);
    tick();
    rst = 0; idle_inputs();
    tick();

    // Single lw slot 1, ALU slot 2
    set_slot1(OP_LW, 32'h100, 32'h0);
    valid_i2 = 1; mem_op_i2 = 8'h00;
    push(32'h1); push(32'h0); push(32'h100); push(32'h0); push(32'hF);
    sample();
    check("s1_en", {31'b0, data_sram_en});
    check("s1_wen", {28'b0, data_sram_wen});
    check("s1_addr", data_sram_addr);
    check("s1_stallreq", {31'b0, stallreq_mem});
    check("s1_sel", {28'b0, sel_i1});
    tick();
    idle_inputs(); data_sram_rdata = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF); push(32'h0);
    sample();
    check("s1_rdata_i1", rdata_i1);
    check("s1_idle_en", {31'b0, data_sram_en});
    tick();

    // Dual: lw 0x100 then lb 0x203
    set_slot1(OP_LW, 32'h100, 32'h0);
    set_slot2(OP_LB, 32'h203, 32'h0);
    push(32'h1); push(32'h100); push(32'h1);
    sample();
    check("d_c0_en", {31'b0, data_sram_en});
    check("d_c0_addr", data_sram_addr);
    check("d_c0_stallreq", {31'b0, stallreq_mem});
    stall = 6'b001111;
    tick();
    stall = 6'b0; data_sram_rdata = 32'h1122_3344;
    push(32'h1); push(32'h200); push(32'h8); push(32'h0);
    sample();
    check("d_c1_en", {31'b0, data_sram_en});
    check("d_c1_addr", data_sram_addr);
    check("d_c1_sel_i2", {28'b0, sel_i2});
    check("d_c1_stallreq", {31'b0, stallreq_mem});
    tick();
    idle_inputs(); data_sram_rdata = 32'hAA00_0000;
    push(32'h1122_3344); push(32'hAA00_0000); push(32'h0);
    sample();
    check("d_c2_rdata_i1", rdata_i1);
    check("d_c2_rdata_i2", rdata_i2);
    check("d_c2_en", {31'b0, data_sram_en});
    tick();
    data_sram_rdata = 32'h5555_5555;
    push(32'h5555_5555);
    sample();
    check("d_c3_rbuf_cleared", rdata_i1);
    tick();

    // Store halfword: aligned, then misaligned
    set_slot1(OP_SH, 32'h102, 32'h0000_BEEF);
    push(32'hC); push(32'hBEEF_BEEF); push(32'h1); push(32'h100);
    sample();
    check("sh_wen", {28'b0, data_sram_wen});
    check("sh_wdata", data_sram_wdata);
    check("sh_en", {31'b0, data_sram_en});
    check("sh_addr", data_sram_addr);
    tick();
    set_slot1(OP_SH, 32'h101, 32'h0000_BEEF);
`ifdef MEM_ALIGN_CHK_EN
    push(32'h1); push(32'h0); push(32'h0);
`else
    push(32'h0); push(32'h1); push(32'h3);
`endif
    sample();
    check("shmis_ades", {31'b0, ades_i1});
    check("shmis_en", {31'b0, data_sram_en});
    check("shmis_wen", {28'b0, data_sram_wen});
    tick();

    // Faulting lw in slot 1 with sw in slot 2
    set_slot1(OP_LW, 32'h101, 32'h0);
    set_slot2(OP_SW, 32'h300, 32'hCAFE_F00D);
`ifdef MEM_ALIGN_CHK_EN
    push(32'h1); push(32'h0); push(32'h0);
    sample();
    check("lwmis_adel", {31'b0, adel_i1});
    check("lwmis_en", {31'b0, data_sram_en});
    check("lwmis_stallreq", {31'b0, stallreq_mem});
    tick();
`else
    push(32'h0); push(32'h1); push(32'h1); push(32'h100);
    sample();
    check("lwmis_adel", {31'b0, adel_i1});
    check("lwmis_en", {31'b0, data_sram_en});
    check("lwmis_stallreq", {31'b0, stallreq_mem});
    check("lwmis_addr", data_sram_addr);
    tick();
    push(32'h300); push(32'hF); push(32'hCAFE_F00D);
    sample();
    check("lwmis_s2_addr", data_sram_addr);
    check("lwmis_s2_wen", {28'b0, data_sram_wen});
    check("lwmis_s2_wdata", data_sram_wdata);
    tick();
`endif
    idle_inputs();
    tick();

    // Flush during SECOND
    set_slot1(OP_LW, 32'h100, 32'h0);
    set_slot2(OP_LW, 32'h200, 32'h0);
    push(32'h1);
    sample();
    check("fl_c0_stallreq", {31'b0, stallreq_mem});
    tick();
    flush = 1; data_sram_rdata = 32'h6666_6666;
    push(32'h0); push(32'h0);
    sample();
    check("fl_c1_en", {31'b0, data_sram_en});
    check("fl_c1_stallreq", {31'b0, stallreq_mem});
    tick();
    flush = 0; idle_inputs(); set_slot1(OP_LW, 32'h600, 32'h0);
    data_sram_rdata = 32'h7777_7777;
    push(32'h1); push(32'h600); push(32'h7777_7777);
    sample();
    check("fl_c2_en", {31'b0, data_sram_en});
    check("fl_c2_addr", data_sram_addr);
    check("fl_c2_rdata_i1", rdata_i1);
    tick();
    idle_inputs();
    tick();

    // External EX stall held two cycles in SECOND
    set_slot1(OP_LW, 32'h400, 32'h0);
    set_slot2(OP_LW, 32'h500, 32'h0);
    push(32'h1);
    sample();
    check("st_c0_stallreq", {31'b0, stallreq_mem});
    tick();
    stall = 6'b001111; data_sram_rdata = 32'h1111_1111;
    push(32'h1); push(32'h500);
    sample();
    check("st_c1_en", {31'b0, data_sram_en});
    check("st_c1_addr", data_sram_addr);
    tick();
    data_sram_rdata = 32'h9999_9999;
    push(32'h1); push(32'h500); push(32'h1111_1111);
    sample();
    check("st_c2_en", {31'b0, data_sram_en});
    check("st_c2_addr", data_sram_addr);
    check("st_c2_rdata_i1", rdata_i1);
    tick();
    stall = 6'b0; data_sram_rdata = 32'h8888_8888;
    push(32'h1); push(32'h500);
    sample();
    check("st_c3_en", {31'b0, data_sram_en});
    check("st_c3_addr", data_sram_addr);
    tick();
    idle_inputs(); data_sram_rdata = 32'h2222_2222;
    push(32'h1111_1111); push(32'h2222_2222); push(32'h0);
    sample();
    check("st_c4_rdata_i1", rdata_i1);
    check("st_c4_rdata_i2", rdata_i2);
    check("st_c4_en", {31'b0, data_sram_en});
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
